// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the fetch interface.
// Accepts one PC-addressed read at a time, waits LATENCY cycles, then returns
// the word with a valid/ready handshake. The program store is written through
// an independent load port. A flush discards any in-flight fetch.
// Optional: define IMEM_PIPELINED_EN so that a new request can be accepted in
// the same cycle the current response is taken, which removes the IDLE bubble.
module imem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  resp_err,
  input  logic                  resp_ready,
  input  logic                  flush,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]          CNT_INIT  = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [3:0]            cnt;
  logic                  rdy_q;
  logic [ADDR_WIDTH-1:0] cap_addr;

  logic                  load_ok;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ok;
  logic [DATA_WIDTH-1:0] fetch_word;
  logic                  accept;

  // Store write port: out-of-range loads are dropped, contents never reset.
  assign load_ok = ({1'b0, load_addr} < DEPTH_LIM);

  always_ff @(posedge clock) begin
    if (load_en && load_ok) begin
      mem[load_addr[IDX_W-1:0]] <= load_data;
    end
  end

  // Read address for the RESP-entry edge: the captured PC when leaving WAIT,
  // otherwise the live request address (LATENCY=1 goes straight to RESP).
  always_comb begin
    fetch_addr = req_addr;
    if (state == S_WAIT) begin
      fetch_addr = cap_addr;
    end
    fetch_ok   = ({1'b0, fetch_addr} < DEPTH_LIM);
    fetch_word = '0;
    if (fetch_ok) begin
      fetch_word = mem[fetch_addr[IDX_W-1:0]];
    end
  end

  // Ready: registered IDLE indication, plus the take-and-refill slot in RESP.
`ifdef IMEM_PIPELINED_EN
  assign req_ready = rdy_q | ((state == S_RESP) && resp_ready && !flush);
`else
  assign req_ready = rdy_q;
`endif

  assign accept = req_valid && req_ready && !flush;

  // Fetch FSM with registered handshake and response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rdy_q      <= 1'b1;
      cap_addr   <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_addr  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_addr <= req_addr;
            rdy_q    <= 1'b0;
            if (LATENCY == 1) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_addr  <= req_addr;
              resp_data  <= fetch_word;
              resp_err   <= !fetch_ok;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end

        S_WAIT: begin
          if (flush) begin
            state <= S_IDLE;
            rdy_q <= 1'b1;
          end else if (cnt == 4'd0) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_addr  <= cap_addr;
            resp_data  <= fetch_word;
            resp_err   <= !fetch_ok;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_RESP: begin
          if (flush) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            rdy_q      <= 1'b1;
          end else if (resp_ready) begin
`ifdef IMEM_PIPELINED_EN
            // The request taken alongside the response skips IDLE entirely.
            if (accept) begin
              cap_addr <= req_addr;
              if (LATENCY == 1) begin
                state      <= S_RESP;
                resp_valid <= 1'b1;
                resp_addr  <= req_addr;
                resp_data  <= fetch_word;
                resp_err   <= !fetch_ok;
              end else begin
                state      <= S_WAIT;
                cnt        <= CNT_INIT;
                resp_valid <= 1'b0;
              end
            end else begin
              state      <= S_IDLE;
              resp_valid <= 1'b0;
              rdy_q      <= 1'b1;
            end
`else
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            rdy_q      <= 1'b1;
`endif
          end
        end

        default: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          rdy_q      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: u0 (DEPTH=200, LATENCY=2) covers the
// basic fetch, backpressure, flush, out-of-range, read-before-write and
// mid-operation reset; u1 (LATENCY=1) covers back-to-back streaming.
module tb_imem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0;
  logic [7:0]  req_addr = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [7:0]  resp_addr;
  logic        resp_err;
  logic        resp_ready = 1'b0;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  logic        req_valid1 = 1'b0;
  logic [7:0]  req_addr1 = '0;
  logic        req_ready1;
  logic        resp_valid1;
  logic [31:0] resp_data1;
  logic [7:0]  resp_addr1;
  logic        resp_err1;
  logic        resp_ready1 = 1'b0;
  logic        flush1 = 1'b0;
  logic        load_en1 = 1'b0;
  logic [7:0]  load_addr1 = '0;
  logic [31:0] load_data1 = '0;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  imem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(200), .LATENCY(2)) u0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_addr(resp_addr),
    .resp_err(resp_err), .resp_ready(resp_ready), .flush(flush),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256), .LATENCY(1)) u1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid1), .req_addr(req_addr1), .req_ready(req_ready1),
    .resp_valid(resp_valid1), .resp_data(resp_data1), .resp_addr(resp_addr1),
    .resp_err(resp_err1), .resp_ready(resp_ready1), .flush(flush1),
    .load_en(load_en1), .load_addr(load_addr1), .load_data(load_data1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held across two edges
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_addr", 32'(resp_addr), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    reset = 1'b1;

    // Program loads: u0 addr5, u1 addrs 0..3
    load_en = 1'b1; load_addr = 8'd5; load_data = 32'hE3A00001;
    load_en1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_addr1 = 8'(i);
      load_data1 = 32'hA0 + 32'(i);
      tick();
      load_en = 1'b0;
    end
    load_en1 = 1'b0;

    // Basic fetch of addr 5, LATENCY=2
    resp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 8'd5;
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    tick();                                  // accept edge
    req_valid = 1'b0;
    chk("wait_valid", 32'(resp_valid), 32'd0);
    chk("wait_req_ready", 32'(req_ready), 32'd0);
    tick();                                  // RESP entry
    chk("b_valid", 32'(resp_valid), 32'd1);
    chk("b_data", resp_data, 32'hE3A00001);
    chk("b_addr", 32'(resp_addr), 32'd5);
    chk("b_err", 32'(resp_err), 32'd0);
    chk("b_req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("b_done_valid", 32'(resp_valid), 32'd0);
    chk("b_done_ready", 32'(req_ready), 32'd1);

    // Backpressure for 4 cycles
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 8'd5;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_valid%0d", i), 32'(resp_valid), 32'd1);
      chk($sformatf("bp_data%0d", i), resp_data, 32'hE3A00001);
      chk($sformatf("bp_addr%0d", i), 32'(resp_addr), 32'd5);
      chk($sformatf("bp_rdy%0d", i), 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_rel_valid", 32'(resp_valid), 32'd0);
    chk("bp_rel_ready", 32'(req_ready), 32'd1);

    // Flush in WAIT
    resp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 8'd5;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fw_valid", 32'(resp_valid), 32'd0);
    chk("fw_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fw_quiet%0d", i), 32'(resp_valid), 32'd0);
    end

    // Flush in RESP with resp_ready=0
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 8'd5;
    tick();
    req_valid = 1'b0;
    tick();
    chk("fr_pre_valid", 32'(resp_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fr_valid", 32'(resp_valid), 32'd0);
    chk("fr_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fr_quiet%0d", i), 32'(resp_valid), 32'd0);
    end

    // Flush in IDLE blocks a simultaneous request (flush beats resp_ready too)
    resp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 8'd5; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("fi_ready", 32'(req_ready), 32'd1);
    tick();
    chk("fi_valid", 32'(resp_valid), 32'd0);

    // Out-of-range request (DEPTH=200)
    req_valid = 1'b1; req_addr = 8'd250;
    tick();
    req_valid = 1'b0;
    tick();
    chk("oor_valid", 32'(resp_valid), 32'd1);
    chk("oor_err", 32'(resp_err), 32'd1);
    chk("oor_data", resp_data, 32'h0);
    chk("oor_addr", 32'(resp_addr), 32'd250);
    tick();
    chk("oor_done", 32'(resp_valid), 32'd0);

    // Read-before-write collision on addr 7
    load_en = 1'b1; load_addr = 8'd7; load_data = 32'h11111111;
    tick();
    load_en = 1'b0;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 8'd7;
    tick();
    req_valid = 1'b0;
    load_en = 1'b1; load_addr = 8'd7; load_data = 32'h22222222;
    tick();                                  // RESP entry and load share this edge
    load_en = 1'b0;
    chk("rbw_valid", 32'(resp_valid), 32'd1);
    chk("rbw_old", resp_data, 32'h11111111);
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b1; req_addr = 8'd7;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rbw_new_valid", 32'(resp_valid), 32'd1);
    chk("rbw_new", resp_data, 32'h22222222);
    tick();

    // Streaming on u1 (LATENCY=1)
    resp_ready1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_valid1 = 1'b1; req_addr1 = 8'(k);
      tick();
      chk($sformatf("st_valid%0d", k), 32'(resp_valid1), 32'd1);
      chk($sformatf("st_data%0d", k), resp_data1, 32'hA0 + 32'(k));
      chk($sformatf("st_addr%0d", k), 32'(resp_addr1), 32'(k));
`ifndef IMEM_PIPELINED_EN
      chk($sformatf("st_rdy%0d", k), 32'(req_ready1), 32'd0);
      tick();
      chk($sformatf("st_gap%0d", k), 32'(resp_valid1), 32'd0);
`endif
    end
    req_valid1 = 1'b0;
    tick();
    chk("st_end_valid", 32'(resp_valid1), 32'd0);
    chk("st_end_ready", 32'(req_ready1), 32'd1);

    // Reset mid-operation on u0
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 8'd5;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mr_pre_valid", 32'(resp_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("mr_valid", 32'(resp_valid), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd1);
    chk("mr_data", resp_data, 32'h0);
    chk("mr_addr", 32'(resp_addr), 32'd0);
    #1;
    reset = 1'b1;
    tick();
    chk("mr_after", 32'(resp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder on the far end of the fetch interface.
- Accepts one PC-addressed read request at a time, waits a fixed access latency, then returns the instruction word with a valid/ready handshake.
- Holds a loadable program store, written through a separate load port by the testbench or boot loader.
- Supports a flush that discards an in-flight fetch on a branch redirect.

Parameters:
- ADDR_WIDTH, 8, width of the request address; matches the PC width.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 256, number of words in the store; must be <= 2**ADDR_WIDTH.
- LATENCY, 2, cycles from request acceptance to resp_valid; legal values 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_addr  in  ADDR_WIDTH  word address (PC) to read.
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  response word valid.
- resp_data  out  DATA_WIDTH  instruction word.
- resp_addr  out  ADDR_WIDTH  address the response belongs to.
- resp_err  out  1  address was >= DEPTH; resp_data is 0.
- resp_ready  in  1  consumer accepts the response.
- flush  in  1  abort any in-flight or pending response.
- load_en  in  1  write load_data into the store.
- load_addr  in  ADDR_WIDTH  store write address.
- load_data  in  DATA_WIDTH  store write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, latency counter=0.
  - req_ready=1, resp_valid=0, resp_data=0, resp_addr=0, resp_err=0.
  - Store contents are not reset.
- IDLE:
  - req_ready=1.
  - Request accepted on the edge where req_valid=1, req_ready=1 and flush=0; req_addr is captured.
  - If LATENCY=1, go to RESP. Otherwise go to WAIT with counter=LATENCY-2.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - At count 0, go to RESP on the next edge.
- Store read timing:
  - The store is read on the edge that enters RESP, and resp_data/resp_addr/resp_err are registered then.
  - First-request latency is exactly LATENCY cycles from the accept edge to resp_valid=1.
- RESP:
  - resp_valid=1.
  - Outputs are held stable while resp_ready=0.
  - On resp_ready=1, return to IDLE; resp_valid drops next cycle.
- Out of range (captured address >= DEPTH): resp_err=1, resp_data=0. The handshake is otherwise normal.
- Load port:
  - Writes on any edge with load_en=1, in any state.
  - Out-of-range load_addr is ignored.
  - If a load and the RESP-entry read target the same address on the same edge, the response returns the old data (read-before-write).
- Flush:
  - In WAIT or RESP, go to IDLE on the next edge with resp_valid=0; no response is ever delivered for that request.
  - In IDLE, a request presented in the same cycle is not accepted.
  - Flush has priority over resp_ready.
- Handshake:
  - resp_valid never deasserts without either resp_ready=1 or flush=1.
  - Only one request is outstanding.
- Reset mid-operation: immediately returns to the reset values; the in-flight request is lost.

Optional Feature:
- Macro: IMEM_PIPELINED_EN.
- Defined:
  - In RESP with resp_ready=1 and flush=0, req_ready=1.
  - A request accepted on that edge goes directly to WAIT (or to RESP with new data if LATENCY=1).
  - Back-to-back throughput is one response per LATENCY cycles with no IDLE bubble; with LATENCY=1, resp_valid stays high across consecutive responses.
- Undefined: req_ready=1 only in IDLE. Every transaction takes at least LATENCY+1 cycles.

Test Plan:
- Load addr 5=0xE3A00001, then request addr 5 with LATENCY=2 and resp_ready=1 → resp_valid on the 2nd edge after accept, resp_data=0xE3A00001, resp_addr=5, resp_err=0, req_ready=0 until the response is taken.
- Backpressure: hold resp_ready=0 for 4 cycles after resp_valid → data and addr stable, req_ready=0; raise resp_ready → next cycle resp_valid=0, req_ready=1.
- Flush in WAIT, and separately flush in RESP with resp_ready=0 → resp_valid=0 next cycle, state IDLE, no response ever appears for that request.
- DEPTH=200, request addr 250 → resp_err=1, resp_data=0, normal handshake.
- Load addr 7=0x11111111, then on the RESP-entry edge load addr 7=0x22222222 → response is 0x11111111; a second read of addr 7 returns 0x22222222.
- With IMEM_PIPELINED_EN and LATENCY=1: stream addrs 0,1,2,3 with resp_ready=1 → four responses on four consecutive cycles. Without the macro → responses every 2 cycles.
